aes_spi_master: RTL and testbench

Parametrised SPI master that moves one AES block plus its cipher key to an encryption or decryption unit and collects the 128-bit result. It supports AES-128/192/256 keys through `NK`, up to four slave channels with per-channel chip-select and MISO, and a programmable SCLK divider. It has a start/done handshake. It sits between the host-side block source and the `encryption_unit`/`decryption_unit` slaves, which run on the same `clk`.

---
 rtl/aes_spi_pkg.sv | 32 +++
 rtl/aes_spi_clkgen.sv | 45 ++++
 rtl/aes_spi_master.sv | 169 ++++++++++++++++
 tb/tb_aes_spi_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI master: FSM encoding, block width and
// elaboration helpers for frame and channel-select widths.
package aes_spi_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_WAIT = 3'd2,
        ST_RX   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_TX   = ST_TX;
    localparam logic [2:0] S_WAIT = ST_WAIT;
    localparam logic [2:0] S_RX   = ST_RX;
    localparam logic [2:0] S_DONE = ST_DONE;
    localparam logic [2:0] S_ERR  = ST_ERR;

    // Outgoing frame: one block followed by NK key words.
    function automatic int txw(input int nk);
        return BLOCK_W + 32 * nk;
    endfunction

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/aes_spi_clkgen.sv
// SCLK generator: low for CLK_DIV cycles, then high for CLK_DIV cycles, with
// strobes marking the clk edges on which sclk rises and falls.
module aes_spi_clkgen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    assign wrap       = (cnt_q == CW'(CLK_DIV - 1));
    assign rise_stb_o = en_i & wrap & ~sclk_q;
    assign fall_stb_o = en_i & wrap & sclk_q;
    assign sclk_o     = sclk_q;

    // Disabling restarts the next enable at the beginning of a low half-period.
    always_comb begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (en_i) begin
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
            sclk_d = wrap ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/aes_spi_master.sv
// SPI master that ships one AES block plus key to a crypto slave and returns
// its 128-bit result. Define AES_SPI_TIMEOUT_EN to bound the WAIT state.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int  NK      = 4,
    parameter int  NCH     = 2,
    parameter int  CLK_DIV = 1,
    parameter int  TIMEOUT = 1024,
    localparam int CH_W    = ch_w(NCH),
    localparam int TXW     = txw(NK)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CH_W-1:0]    ch_sel,
    input  logic [127:0]       msg_in,
    input  logic [32*NK-1:0]   key_in,
    output logic               ready,
    output logic               done,
    output logic               err,
    output logic [127:0]       data_out,
    output logic               sclk,
    output logic               mosi,
    input  logic [NCH-1:0]     miso,
    output logic [NCH-1:0]     cs
);

    localparam int BW = $clog2(TXW + 1);

    logic [2:0]         state_q, state_d;
    logic [TXW-1:0]     tx_q, tx_d;
    logic [BLOCK_W-1:0] rx_q, rx_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [NCH-1:0]     cs_q, cs_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               miso_sel, rise_stb, fall_stb, clk_en;

    assign miso_sel = miso[ch_q];
    assign clk_en   = (state_q == S_TX) || (state_q == S_RX);

    aes_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_i      (clk),
        .rst_ni     (rst),
        .en_i       (clk_en),
        .sclk_o     (sclk),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

`ifdef AES_SPI_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0] to_q, to_d;

    assign to_d = (state_q == S_WAIT) ? to_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) to_q <= '0;
        else      to_q <= to_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            // ERR is a one-cycle notification and accepts a new request like IDLE.
            S_IDLE, S_ERR: begin
                if (start) begin
                    if (int'(ch_sel) < NCH) begin
                        state_d      = S_TX;
                        tx_d         = {msg_in, key_in};
                        bit_d        = BW'(TXW);
                        ch_d         = ch_sel;
                        cs_d         = '0;
                        cs_d[ch_sel] = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TX: begin
                if (fall_stb) begin
                    tx_d  = {tx_q[TXW-2:0], 1'b0};
                    bit_d = bit_q - 1'b1;
                    if (bit_q == BW'(1)) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (miso_sel) begin
                    state_d = S_RX;
                    bit_d   = BW'(BLOCK_W);
                end
`ifdef AES_SPI_TIMEOUT_EN
                else if (to_q == TOW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    cs_d    = '0;
                end
`endif
            end
            S_RX: begin
                if (rise_stb) rx_d = {rx_q[BLOCK_W-2:0], miso_sel};
                if (fall_stb) begin
                    bit_d = bit_q - 1'b1;
                    if (bit_q == BW'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                data_d  = rx_q;
                done_d  = 1'b1;
                cs_d    = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
            cs_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready    = (state_q == S_IDLE) || (state_q == S_ERR);
    assign done     = done_q;
    assign err      = err_q;
    assign data_out = data_q;
    assign mosi     = tx_q[TXW-1];
    assign cs       = cs_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: two configurations (NK=4/CLK_DIV=1 and
// NK=8/CLK_DIV=3/NCH=3) driven by a behavioural SPI slave.
module tb_aes_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start0, start1;
    logic         ch_sel0;
    logic [1:0]   ch_sel1;
    logic [127:0] msg0, msg1;
    logic [127:0] key0;
    logic [255:0] key1;
    logic         ready0, done0, err0, sclk0, mosi0;
    logic         ready1, done1, err1, sclk1, mosi1;
    logic [127:0] data0, data1;
    logic [1:0]   miso0, cs0;
    logic [2:0]   miso1, cs1;

    aes_spi_master #(.NK(4), .NCH(2), .CLK_DIV(1), .TIMEOUT(16)) u0 (
        .clk(clk), .rst(rst), .start(start0), .ch_sel(ch_sel0), .msg_in(msg0),
        .key_in(key0), .ready(ready0), .done(done0), .err(err0), .data_out(data0),
        .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs(cs0)
    );

    aes_spi_master #(.NK(8), .NCH(3), .CLK_DIV(3), .TIMEOUT(16)) u1 (
        .clk(clk), .rst(rst), .start(start1), .ch_sel(ch_sel1), .msg_in(msg1),
        .key_in(key1), .ready(ready1), .done(done1), .err(err1), .data_out(data1),
        .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs(cs1)
    );

    typedef struct {
        bit           sel;
        int           ch;
        logic [127:0] msg;
        logic [255:0] key;
        int           extra;
        logic [127:0] exp;
    } vec_t;

    vec_t vec[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [383:0] s_frame;
    int           s_hmin, s_hmax, d_lat, d_bad;
    bit           s_ok, d_seen;

    task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic get_sclk(input bit sel);
        return sel ? sclk1 : sclk0;
    endfunction
    function automatic logic get_mosi(input bit sel);
        return sel ? mosi1 : mosi0;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? done1 : done0;
    endfunction
    function automatic logic get_ready(input bit sel);
        return sel ? ready1 : ready0;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? err1 : err0;
    endfunction
    function automatic logic [3:0] get_cs(input bit sel);
        return sel ? {1'b0, cs1} : {2'b00, cs0};
    endfunction
    function automatic logic [127:0] get_data(input bit sel);
        return sel ? data1 : data0;
    endfunction

    task automatic set_miso(input bit sel, input int ch, input logic v);
        if (sel) miso1[ch] = v;
        else     miso0[ch] = v;
    endtask

    // Slave: collect nbits on sclk rises, raise the ready flag, return resp MSB first.
    task automatic slave(input bit sel, input int ch, input int nbits, input logic [127:0] resp,
                         input int extra, input bit respond);
        logic       p, s, found;
        logic [3:0] c;
        int         hi, n, g;
        s_frame = '0; s_hmin = 9999; s_hmax = 0; s_ok = 1'b1;
        hi = 0; n = 0; g = 0;
        c = get_cs(sel);
        while (!c[ch] && g < 100) begin
            @(negedge clk);
            c = get_cs(sel);
            g++;
        end
        if (!c[ch]) begin s_ok = 1'b0; return; end
        p = get_sclk(sel);
        g = 0;
        while ((n < nbits || p) && g < 20000) begin
            @(negedge clk);
            g++;
            s = get_sclk(sel);
            if (s && !p) begin s_frame = {s_frame[382:0], get_mosi(sel)}; n++; hi = 0; end
            if (s) hi++;
            if (!s && p) begin
                s_hmin = (hi < s_hmin) ? hi : s_hmin;
                s_hmax = (hi > s_hmax) ? hi : s_hmax;
            end
            p = s;
        end
        if (g >= 20000) begin s_ok = 1'b0; return; end
        if (!respond) return;
        repeat (extra) @(negedge clk);
        set_miso(sel, ch, 1'b1);
        @(negedge clk);
        for (int i = 127; i >= 0; i--) begin
            set_miso(sel, ch, resp[i]);
            g = 0;
            p = get_sclk(sel);
            found = 1'b0;
            while (!found && g < 100) begin
                @(negedge clk);
                s = get_sclk(sel);
                found = p && !s;
                p = s;
                g++;
            end
            if (!found) begin s_ok = 1'b0; set_miso(sel, ch, 1'b0); return; end
        end
        set_miso(sel, ch, 1'b0);
    endtask

    // Issue a request and count cycles until done; the request cycle is cycle 0.
    task automatic drive(input bit sel, input int ch, input logic [127:0] msg, input logic [255:0] key);
        logic [3:0] c;
        @(negedge clk);
        if (sel) begin start1 = 1'b1; ch_sel1 = 2'(ch); msg1 = msg; key1 = key; end
        else     begin start0 = 1'b1; ch_sel0 = 1'(ch); msg0 = msg; key0 = key[127:0]; end
        d_lat = 0; d_seen = 1'b0; d_bad = 0;
        for (int k = 1; k < 20000 && !d_seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start0 = 1'b0; start1 = 1'b0;
                msg0 = ~msg0; key0 = ~key0; ch_sel0 = ~ch_sel0;
                msg1 = ~msg1; key1 = ~key1; ch_sel1 = ch_sel1 ^ 2'd1;
                if (get_ready(sel)) d_bad++;
            end
            c = get_cs(sel);
            if (get_err(sel)) d_bad++;
            if (get_done(sel)) begin
                d_seen = 1'b1;
                d_lat  = k + 1;
                if (c != 4'd0 || !get_ready(sel)) d_bad++;
            end else if (c != (4'b0001 << ch)) begin
                d_bad++;
            end
        end
    endtask

    task automatic run_vec(input int i);
        int           nk, div, exp_lat;
        logic [383:0] exp_frame;
        nk  = vec[i].sel ? 8 : 4;
        div = vec[i].sel ? 3 : 1;
        exp_lat   = 1 + (128 + 32 * nk) * 2 * div + (vec[i].extra + 1) + 1 + 128 * 2 * div + 1;
        exp_frame = vec[i].sel ? {vec[i].msg, vec[i].key} : {128'h0, vec[i].msg, vec[i].key[127:0]};
        fork
            slave(vec[i].sel, vec[i].ch, vec[i].sel ? 384 : 256, vec[i].exp, vec[i].extra, 1'b1);
            drive(vec[i].sel, vec[i].ch, vec[i].msg, vec[i].key);
        join
        check($sformatf("v%0d slave_ok", i), s_ok, 1);
        check($sformatf("v%0d frame", i), s_frame, exp_frame);
        check($sformatf("v%0d sclk_half", i), {s_hmin, s_hmax}, {div, div});
        check($sformatf("v%0d done_seen", i), d_seen, 1);
        check($sformatf("v%0d latency", i), d_lat, exp_lat);
        check($sformatf("v%0d data_out", i), get_data(vec[i].sel), vec[i].exp);
        check($sformatf("v%0d cs_ready_err", i), d_bad, 0);
        @(negedge clk);
        check($sformatf("v%0d done_pulse_hold", i),
              {get_done(vec[i].sel), get_data(vec[i].sel)}, {1'b0, vec[i].exp});
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errk;
        bit dseen;
        logic [1:0] csat;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; ch_sel0 = 1'b0; ch_sel1 = 2'd0;
        msg0 = '0; msg1 = '0; key0 = '0; key1 = '0; miso0 = '0; miso1 = '0;

        vec[0] = '{1'b0, 0, 128'h00112233445566778899aabbccddeeff,
                   256'h000102030405060708090a0b0c0d0e0f, 0,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vec[1] = '{1'b0, 1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                   256'h000102030405060708090a0b0c0d0e0f, 3,
                   128'h00112233445566778899aabbccddeeff};
        vec[2] = '{1'b1, 2, 128'h00112233445566778899aabbccddeeff,
                   256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2,
                   128'h8ea2b7ca516745bfeafc49904b496089};
        vec[3] = '{1'b1, 0, 128'h0123456789abcdeffedcba9876543210,
                   256'hf0e1d2c3b4a5968778695a4b3c2d1e0f0f1e2d3c4b5a69788796a5b4c3d2e1f0, 0,
                   128'hc3c35a5a0ff0a55a123456789abcdef0};

        repeat (3) @(negedge clk);
        check("reset u0 ctrl", {ready0, done0, err0, sclk0, mosi0, cs0}, 7'b1000000);
        check("reset u0 data", data0, 128'h0);
        check("reset u1 ctrl", {ready1, done1, err1, sclk1, mosi1, cs1}, 8'b10000000);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Illegal channel on the three-channel instance.
        @(negedge clk);
        start1 = 1'b1; ch_sel1 = 2'd3;
        @(negedge clk);
        start1 = 1'b0;
        check("badch err cycle", {err1, cs1, ready1}, {1'b1, 3'b000, 1'b1});
        @(negedge clk);
        check("badch after", {err1, cs1, ready1, done1}, {1'b0, 3'b000, 1'b1, 1'b0});
        check("badch data held", data1, vec[3].exp);

        // Reset asserted while bit 200 of the outgoing frame is on the wire.
        @(negedge clk);
        start0 = 1'b1; ch_sel0 = 1'b0; msg0 = vec[0].msg; key0 = vec[0].key[127:0];
        @(negedge clk);
        start0 = 1'b0;
        repeat (400) @(negedge clk);
        check("midframe cs", cs0, 2'b01);
        rst = 1'b0;
        #1;
        check("midframe reset ctrl", {ready0, done0, err0, sclk0, mosi0, cs0}, 7'b1000000);
        check("midframe reset data", {data0, data1}, 256'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_vec(0);

`ifdef AES_SPI_TIMEOUT_EN
        @(negedge clk);
        start0 = 1'b1; ch_sel0 = 1'b1; msg0 = vec[1].msg; key0 = vec[1].key[127:0];
        errk = 0; dseen = 1'b0; csat = 2'b11;
        for (int k = 1; k < 700 && errk == 0; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (done0) dseen = 1'b1;
            if (err0) begin errk = k; csat = cs0; end
        end
        check("timeout cycle", errk, 512 + 1 + 16);
        check("timeout cs", csat, 2'b00);
        check("timeout no done", dseen, 1'b0);
        check("timeout data held", data0, vec[0].exp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
